// File: rtl/ibuf_cons_ctrl_pkg.sv
// Shared definitions for the ibuf consumer controller and the frame writer:
// header bit-field positions, FSM state encodings and qword arithmetic.
package ibuf_cons_ctrl_pkg;

    // Byte length field inside a header word
    localparam int LEN_HI = 47;
    localparam int LEN_LO = 32;

    // Width used for qword counts derived from a 16-bit byte length
    localparam int QW_W = 17;

    typedef enum logic [2:0] {
        INIT      = 3'd0,
        WAIT_HOST = 3'd1,
        IDLE      = 3'd2,
        RD_HDR    = 3'd3,
        PARSE     = 3'd4,
        REQ       = 3'd5,
        WAIT_DONE = 3'd6,
        COMMIT    = 3'd7
    } state_t;

    // Number of 64-bit words needed to hold len bytes; 17 bits so that
    // len = 16'hFFFF cannot overflow the rounding add.
    function automatic logic [QW_W-1:0] len_to_qw(input logic [15:0] len);
        logic [QW_W-1:0] sum;
        sum = {1'b0, len} + 17'd7;
        return sum >> 3;
    endfunction

endpackage

// File: rtl/ibuf_cons_ctrl.sv
// Consumer side of the ingress buffer: walks committed packets, splits each
// into DMA bursts of at most MAX_BURST qwords and frees the slots once the
// DMA engine reports the last burst read.
module ibuf_cons_ctrl
    import ibuf_cons_ctrl_pkg::*;
#(
    parameter int BW        = 10,
    parameter int MAX_BURST = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hst_rdy,
    input  logic [BW:0]   committed_prod,
    output logic [BW:0]   committed_cons,
    output logic [BW-1:0] rd_addr,
    input  logic [63:0]   rd_data,
    output logic          burst_req,
    input  logic          burst_ack,
    output logic [BW-1:0] burst_addr,
    output logic [6:0]    burst_qw,
    output logic [15:0]   burst_len,
    output logic          burst_sop,
    output logic          burst_eop,
    input  logic          burst_done,
    output logic [31:0]   fwd_pkts,
    output logic [15:0]   bad_hdrs
);

    typedef logic [BW:0] ptr_t;

    localparam logic [QW_W-1:0] MAX_QW   = QW_W'(MAX_BURST);
    // Largest packet body that still leaves room for its header in the ring
    localparam logic [QW_W-1:0] QW_LIMIT = QW_W'((1 << BW) - 2);

    state_t          state_reg, state_next;
    logic            hst_meta_reg, hst_sync_reg;
    ptr_t            cons_reg;
    ptr_t            slot_reg;
    logic [QW_W-1:0] remain_reg;
    logic [BW-1:0]   rd_addr_reg;
    logic            burst_req_reg;
    logic [BW-1:0]   burst_addr_reg;
    logic [6:0]      burst_qw_reg;
    logic [15:0]     burst_len_reg;
    logic            burst_sop_reg;
    logic            burst_eop_reg;
    logic [31:0]     fwd_pkts_reg;
    logic [15:0]     bad_hdrs_reg;

    logic            pkt_pending;
    logic [15:0]     hdr_len;
    logic [QW_W-1:0] hdr_qw;
    logic            hdr_bad;
    ptr_t            hdr_slot;
    logic [QW_W-1:0] remain_after;
    ptr_t            slot_after;
    logic            unused_rd_bits;

    // Clamp a remaining qword count to the largest allowed burst
    function automatic logic [6:0] clamp_qw(input logic [QW_W-1:0] rem);
        return (rem > MAX_QW) ? 7'(MAX_BURST) : rem[6:0];
    endfunction

    assign pkt_pending  = (committed_prod != cons_reg);
    assign hdr_len      = rd_data[LEN_HI:LEN_LO];
    assign hdr_qw       = len_to_qw(hdr_len);
    assign hdr_bad      = (hdr_len == 16'd0) || (hdr_qw > QW_LIMIT);
    assign hdr_slot     = cons_reg + ptr_t'(1);
    assign remain_after = remain_reg - QW_W'(burst_qw_reg);
    assign slot_after   = slot_reg + ptr_t'(burst_qw_reg);

    // Only the length field of the header word matters here
    assign unused_rd_bits = ^{rd_data[63:LEN_HI+1], rd_data[LEN_LO-1:0]};

    // Two-flop synchroniser for the host-ready level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hst_meta_reg <= 1'b0;
            hst_sync_reg <= 1'b0;
        end else begin
            hst_meta_reg <= hst_rdy;
            hst_sync_reg <= hst_meta_reg;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; host-ready loss only takes effect between packets
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            INIT:      state_next = WAIT_HOST;
            WAIT_HOST: if (hst_sync_reg) state_next = IDLE;
            IDLE: begin
                if (!hst_sync_reg) begin
                    state_next = WAIT_HOST;
                end else if (pkt_pending) begin
                    state_next = RD_HDR;
                end
            end
            RD_HDR:    state_next = PARSE;
            PARSE:     state_next = hdr_bad ? IDLE : REQ;
            REQ: begin
                if (burst_ack) begin
                    state_next = (remain_after != '0) ? REQ : WAIT_DONE;
                end
            end
            WAIT_DONE: if (burst_done) state_next = COMMIT;
            COMMIT:    state_next = IDLE;
            default:   state_next = INIT;
        endcase
    end

    // Pointer, burst descriptor and statistics registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cons_reg       <= '0;
            slot_reg       <= '0;
            remain_reg     <= '0;
            rd_addr_reg    <= '0;
            burst_req_reg  <= 1'b0;
            burst_addr_reg <= '0;
            burst_qw_reg   <= '0;
            burst_len_reg  <= '0;
            burst_sop_reg  <= 1'b0;
            burst_eop_reg  <= 1'b0;
            fwd_pkts_reg   <= '0;
            bad_hdrs_reg   <= '0;
        end else begin
            case (state_reg)
                INIT: begin
                    cons_reg     <= '0;
                    fwd_pkts_reg <= '0;
                    bad_hdrs_reg <= '0;
                end
                IDLE: begin
                    if (hst_sync_reg && pkt_pending) begin
                        rd_addr_reg <= cons_reg[BW-1:0];
                    end
                end
                PARSE: begin
                    burst_len_reg <= hdr_len;
                    remain_reg    <= hdr_qw;
                    slot_reg      <= hdr_slot;
                    if (hdr_bad) begin
                        // Skip just the header slot and keep scanning
                        cons_reg <= hdr_slot;
                        if (bad_hdrs_reg != 16'hFFFF) begin
                            bad_hdrs_reg <= bad_hdrs_reg + 16'd1;
                        end
                    end else begin
                        burst_req_reg  <= 1'b1;
                        burst_addr_reg <= hdr_slot[BW-1:0];
                        burst_qw_reg   <= clamp_qw(hdr_qw);
                        burst_eop_reg  <= (hdr_qw <= MAX_QW);
                        burst_sop_reg  <= 1'b1;
                    end
                end
                REQ: begin
                    // Descriptor only moves on acceptance, so it holds while stalled
                    if (burst_ack) begin
                        slot_reg      <= slot_after;
                        remain_reg    <= remain_after;
                        burst_sop_reg <= 1'b0;
                        if (remain_after != '0) begin
                            burst_addr_reg <= slot_after[BW-1:0];
                            burst_qw_reg   <= clamp_qw(remain_after);
                            burst_eop_reg  <= (remain_after <= MAX_QW);
                        end else begin
                            burst_req_reg <= 1'b0;
                        end
                    end
                end
                COMMIT: begin
                    cons_reg     <= slot_reg;
                    fwd_pkts_reg <= fwd_pkts_reg + 32'd1;
                end
                default: ;
            endcase
        end
    end

    assign committed_cons = cons_reg;
    assign rd_addr        = rd_addr_reg;
    assign burst_req      = burst_req_reg;
    assign burst_addr     = burst_addr_reg;
    assign burst_qw       = burst_qw_reg;
    assign burst_len      = burst_len_reg;
    assign burst_sop      = burst_sop_reg;
    assign burst_eop      = burst_eop_reg;
    assign fwd_pkts       = fwd_pkts_reg;
    assign bad_hdrs       = bad_hdrs_reg;

endmodule

// File: tb/tb_ibuf_cons_ctrl.sv
// Bench for ibuf_cons_ctrl: ibuf memory with one-cycle read, a DMA responder,
// and a packet-level model that expands each committed packet into its
// expected burst list and expected consumer-pointer values.
module tb_ibuf_cons_ctrl;

    localparam int BW    = 10;
    localparam int MAXB  = 16;
    localparam int NSLOT = 1 << BW;
    localparam int PMOD  = 2 << BW;

    typedef logic [BW:0] prod_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          hst_rdy;
    logic [BW:0]   committed_prod;
    logic [BW:0]   committed_cons;
    logic [BW-1:0] rd_addr;
    logic [63:0]   rd_data;
    logic          burst_req;
    logic          burst_ack;
    logic [BW-1:0] burst_addr;
    logic [6:0]    burst_qw;
    logic [15:0]   burst_len;
    logic          burst_sop;
    logic          burst_eop;
    logic          burst_done;
    logic [31:0]   fwd_pkts;
    logic [15:0]   bad_hdrs;

    logic [63:0] mem [NSLOT];

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr];

    ibuf_cons_ctrl #(.BW(BW), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst(rst), .hst_rdy(hst_rdy),
        .committed_prod(committed_prod), .committed_cons(committed_cons),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .burst_req(burst_req), .burst_ack(burst_ack),
        .burst_addr(burst_addr), .burst_qw(burst_qw), .burst_len(burst_len),
        .burst_sop(burst_sop), .burst_eop(burst_eop), .burst_done(burst_done),
        .fwd_pkts(fwd_pkts), .bad_hdrs(bad_hdrs)
    );

    typedef struct { int addr; int qw; int len; bit sop; bit eop; } burst_t;
    typedef struct { int val; bit needs_done; } cons_t;

    burst_t burst_q[$];
    cons_t  cons_q[$];
    burst_t acc_log[$];

    int checks = 0;
    int errors = 0;
    int model_prod, last_cons, done_cnt, good_commits, fwd_exp, bad_exp;
    int ack_delay  = 0;
    int done_delay = 2;
    int stray_req  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model + DMA responder + per-cycle compare
    initial begin : monitor
        int waited, done_cd, stray_seen, guard;
        int h, len, qw, rem, slot;
        bit first;
        burst_t b, la;
        cons_t c;
        waited = 0; done_cd = 0; stray_seen = 0;
        model_prod = 0; last_cons = 0; done_cnt = 0; good_commits = 0;
        fwd_exp = 0; bad_exp = 0;
        burst_ack = 1'b0; burst_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                burst_ack = 1'b0; burst_done = 1'b0;
                waited = 0; done_cd = 0; stray_seen = stray_req;
                burst_q.delete(); cons_q.delete();
                model_prod = 0; last_cons = 0; done_cnt = 0; good_commits = 0;
                fwd_exp = 0; bad_exp = 0;
            end else begin
                guard = 0;
                while (model_prod != int'(committed_prod) && guard < 8) begin
                    h   = model_prod;
                    len = int'(mem[h % NSLOT][47:32]);
                    qw  = (len + 7) / 8;
                    if (len == 0 || qw > NSLOT - 2) begin
                        c.val = (h + 1) % PMOD; c.needs_done = 1'b0;
                        if (bad_exp < 65535) bad_exp++;
                    end else begin
                        rem = qw; slot = (h + 1) % PMOD; first = 1'b1;
                        while (rem > 0) begin
                            b.qw   = (rem < MAXB) ? rem : MAXB;
                            b.addr = slot % NSLOT;
                            b.len  = len;
                            b.sop  = first;
                            b.eop  = (rem <= MAXB);
                            burst_q.push_back(b);
                            slot  = (slot + b.qw) % PMOD;
                            rem  -= b.qw;
                            first = 1'b0;
                        end
                        c.val = (h + 1 + qw) % PMOD; c.needs_done = 1'b1;
                        fwd_exp++;
                    end
                    cons_q.push_back(c);
                    model_prod = c.val;
                    guard++;
                end
                if (guard == 8) begin
                    chk("model_prod_sync", model_prod, committed_prod);
                    model_prod = int'(committed_prod);
                end

                burst_done = 1'b0;
                if (done_cd > 0) begin
                    done_cd--;
                    if (done_cd == 0) begin
                        burst_done = 1'b1;
                        done_cnt++;
                    end
                end else if (stray_seen != stray_req) begin
                    burst_done = 1'b1;
                    stray_seen++;
                end

                burst_ack = 1'b0;
                if (burst_req) begin
                    if (burst_q.size() == 0) begin
                        chk("burst_unexpected", burst_req, 0);
                    end else begin
                        b = burst_q[0];
                        chk("burst_addr", burst_addr, b.addr);
                        chk("burst_qw",   burst_qw,   b.qw);
                        chk("burst_len",  burst_len,  b.len);
                        chk("burst_sop",  burst_sop,  b.sop);
                        chk("burst_eop",  burst_eop,  b.eop);
                        if (waited >= ack_delay) begin
                            burst_ack = 1'b1;
                            la.addr = int'(burst_addr); la.qw = int'(burst_qw);
                            la.len = int'(burst_len); la.sop = burst_sop; la.eop = burst_eop;
                            acc_log.push_back(la);
                            void'(burst_q.pop_front());
                            waited = 0;
                            if (b.eop) done_cd = done_delay;
                        end else begin
                            waited++;
                        end
                    end
                end else begin
                    waited = 0;
                end

                if (int'(committed_cons) != last_cons) begin
                    if (cons_q.size() == 0) begin
                        chk("cons_unexpected", committed_cons, last_cons);
                    end else begin
                        c = cons_q.pop_front();
                        chk("cons_value", committed_cons, c.val);
                        if (c.needs_done) begin
                            chk("commit_before_done", (done_cnt > good_commits), 1);
                            good_commits++;
                        end
                    end
                    last_cons = int'(committed_cons);
                end
                chk("cons_not_past_prod",
                    (((int'(committed_prod) - int'(committed_cons) + PMOD) % PMOD) <= NSLOT), 1);
            end
        end
    end

    // Frame-writer stand-in: fill header and data words, then publish
    task automatic put_pkt(input int h, input int len);
        int qw;
        logic [63:0] w;
        qw = (len + 7) / 8;
        if (len != 0 && qw <= NSLOT - 2) begin
            for (int i = 1; i <= qw; i++) mem[(h + i) % NSLOT] = {$urandom(), $urandom()};
            committed_prod = prod_t'((h + 1 + qw) % PMOD);
        end else begin
            committed_prod = prod_t'((h + 1) % PMOD);
        end
        w = {$urandom(), $urandom()};
        w[47:32] = 16'(len);
        mem[h % NSLOT] = w;
        $display("pkt hdr=%0d len=%0d prod=%0d", h, len, committed_prod);
    endtask

    task automatic wait_drain(input string name, output int cycles);
        int n;
        n = 0;
        @(negedge clk);
        while ((burst_q.size() != 0 || cons_q.size() != 0 ||
                model_prod != int'(committed_prod)) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        cycles = n;
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_drain_timeout"}, (n < 3000), 1);
        chk({name, "_fwd"}, fwd_pkts, fwd_exp);
        chk({name, "_bad"}, bad_hdrs, bad_exp);
        $display("done %s cons=%0d fwd=%0d bad=%0d", name, committed_cons, fwd_pkts, bad_hdrs);
    endtask

    task automatic wait_acc(input int target, input string name);
        int n;
        n = 0;
        while (acc_log.size() < target && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({name, "_acc_timeout"}, (n < 2000), 1);
    endtask

    initial begin : stim
        int base, cyc, nsop, neop;
        rst = 1'b1; hst_rdy = 1'b0; committed_prod = '0;
        for (int i = 0; i < NSLOT; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cons", committed_cons, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_req", burst_req, 0);
        chk("rst_addr", burst_addr, 0);
        chk("rst_qw", burst_qw, 0);
        chk("rst_len", burst_len, 0);
        chk("rst_sop", burst_sop, 0);
        chk("rst_eop", burst_eop, 0);
        chk("rst_fwd", fwd_pkts, 0);
        chk("rst_bad", bad_hdrs, 0);
        rst = 1'b0;

        // Host not ready: nothing may be issued
        put_pkt(0, 32);
        repeat (10) begin
            @(posedge clk); #1;
            chk("nordy_req", burst_req, 0);
        end
        chk("nordy_cons", committed_cons, 0);
        hst_rdy = 1'b1;
        wait_drain("pkt32", cyc);
        chk("pkt32_cons", committed_cons, 5);

        // Zero-length header, then a stray done while idle
        put_pkt(5, 0);
        wait_drain("len0", cyc);
        chk("len0_cons", committed_cons, 6);
        chk("len0_bad", bad_hdrs, 1);
        stray_req++;
        repeat (6) @(posedge clk);
        #1;
        chk("stray_cons", committed_cons, 6);
        chk("stray_fwd", fwd_pkts, 1);

        // 1514-byte packet; host-ready drops mid-packet
        base = acc_log.size();
        put_pkt(6, 1514);
        wait_acc(base + 1, "p1514");
        hst_rdy = 1'b0;
        wait_drain("p1514", cyc);
        nsop = 0; neop = 0;
        for (int i = base; i < acc_log.size(); i++) begin
            nsop += int'(acc_log[i].sop);
            neop += int'(acc_log[i].eop);
        end
        chk("p1514_bursts", acc_log.size() - base, 12);
        chk("p1514_sop_cnt", nsop, 1);
        chk("p1514_eop_cnt", neop, 1);
        chk("p1514_first_sop", acc_log[base].sop, 1);
        chk("p1514_first_qw", acc_log[base].qw, 16);
        chk("p1514_last_qw", acc_log[acc_log.size() - 1].qw, 14);
        chk("p1514_last_eop", acc_log[acc_log.size() - 1].eop, 1);
        chk("p1514_cons", committed_cons, 197);

        // Host still not ready: next packet waits; stray done mid-packet
        put_pkt(197, 6576);
        repeat (10) begin
            @(posedge clk); #1;
            chk("rdy_low_req", burst_req, 0);
        end
        chk("rdy_low_cons", committed_cons, 197);
        base = acc_log.size();
        hst_rdy = 1'b1;
        wait_acc(base + 5, "p6576");
        stray_req++;
        wait_drain("p6576", cyc);
        chk("p6576_bursts", acc_log.size() - base, 52);
        chk("p6576_cons", committed_cons, 1020);

        // Packet straddling the ibuf wrap point
        base = acc_log.size();
        put_pkt(1020, 64);
        wait_drain("wrap", cyc);
        chk("wrap_addr", acc_log[base].addr, 1021);
        chk("wrap_qw", acc_log[base].qw, 8);
        chk("wrap_cons", committed_cons, 1029);
        chk("wrap_cons_msb", committed_cons[BW], 1);
        chk("wrap_no_stall", (cyc <= 20), 1);

        // Oversized header (1023 qwords) is skipped; 1022 qwords is accepted
        put_pkt(1029, 8184);
        wait_drain("big_bad", cyc);
        chk("big_bad_cons", committed_cons, 1030);
        chk("big_bad_cnt", bad_hdrs, 2);
        base = acc_log.size();
        put_pkt(1030, 8176);
        wait_drain("max_ok", cyc);
        chk("max_ok_bursts", acc_log.size() - base, 64);
        chk("max_ok_addr", acc_log[base].addr, 7);
        chk("max_ok_cons", committed_cons, 5);

        // DMA stalls 20 cycles per burst
        ack_delay = 20;
        base = acc_log.size();
        put_pkt(5, 200);
        wait_drain("stall", cyc);
        ack_delay = 0;
        chk("stall_bursts", acc_log.size() - base, 2);
        chk("stall_qw1", acc_log[acc_log.size() - 1].qw, 9);
        chk("stall_cons", committed_cons, 31);

        // Reset while waiting for done drops the packet
        done_delay = 40;
        base = acc_log.size();
        put_pkt(31, 40);
        wait_acc(base + 1, "rst_mid");
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_cons_held", committed_cons, 31);
        rst = 1'b1;
        committed_prod = '0;
        @(posedge clk);
        #1;
        chk("rstmid_cons", committed_cons, 0);
        chk("rstmid_req", burst_req, 0);
        chk("rstmid_addr", burst_addr, 0);
        chk("rstmid_qw", burst_qw, 0);
        chk("rstmid_len", burst_len, 0);
        chk("rstmid_sop", burst_sop, 0);
        chk("rstmid_eop", burst_eop, 0);
        chk("rstmid_rd_addr", rd_addr, 0);
        chk("rstmid_fwd", fwd_pkts, 0);
        chk("rstmid_bad", bad_hdrs, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        done_delay = 2;

        // Single 60-byte packet at slot 0
        base = acc_log.size();
        put_pkt(0, 60);
        wait_drain("p60", cyc);
        chk("p60_bursts", acc_log.size() - base, 1);
        chk("p60_addr", acc_log[base].addr, 1);
        chk("p60_qw", acc_log[base].qw, 8);
        chk("p60_len", acc_log[base].len, 60);
        chk("p60_sop", acc_log[base].sop, 1);
        chk("p60_eop", acc_log[base].eop, 1);
        chk("p60_cons", committed_cons, 9);
        chk("p60_fwd", fwd_pkts, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ibuf_cons_ctrl.md
IBUF_CONS_CTRL -- requirements
Module: ibuf_cons_ctrl

Interface
REQ-001 Parameter BW, default 10, ibuf address width; ibuf holds 2**BW 64-bit words.
REQ-002 Parameter MAX_BURST, default 16, maximum qwords per DMA burst request (power of two, 1..64).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 hst_rdy  in  1  host ring configured; asynchronous to the block's behaviour, used only after two-flop synchronisation.
REQ-006 committed_prod  in  BW+1  producer pointer from frame writer; slot of next header to be written.
REQ-007 committed_cons  out  BW+1  consumer pointer; slots below it are free.
REQ-008 rd_addr  out  BW  ibuf read address; rd_data valid exactly one cycle after rd_addr is driven.
REQ-009 rd_data  in  64  ibuf read data.
REQ-010 burst_req  out  1  DMA burst request valid.
REQ-011 burst_ack  in  1  DMA engine accepts the request in the cycle burst_req and burst_ack are both high.
REQ-012 burst_addr  out  BW  first ibuf slot of the burst.
REQ-013 burst_qw  out  7  qword count of the burst, 1..MAX_BURST.
REQ-014 burst_len  out  16  packet byte length, valid with burst_req.
REQ-015 burst_sop / burst_eop  out  1 each  first / last burst of the packet.
REQ-016 burst_done  in  1  one-cycle pulse; the last acked burst has been fully read from ibuf.
REQ-017 fwd_pkts  out  32  packets forwarded; bad_hdrs  out  16  headers skipped.

Function
REQ-018 The packet format in ibuf SHALL be: header word at slot H with byte length in bits [47:32], followed by ceil(len/8) data words at H+1 onward; all slot arithmetic SHALL be modulo 2**(BW+1) on pointers, with address = pointer[BW-1:0].
REQ-019 FSM states SHALL be: INIT, WAIT_HOST, IDLE, RD_HDR, PARSE, REQ, WAIT_DONE, COMMIT.
REQ-020 INIT: clear counters and pointer, go to WAIT_HOST; WAIT_HOST: go to IDLE when the synchronised hst_rdy is high.
REQ-021 IDLE: when committed_prod != committed_cons, drive rd_addr = committed_cons and go to RD_HDR; otherwise stay.
REQ-022 RD_HDR: one wait cycle for read latency, then PARSE.
REQ-023 PARSE: latch len = rd_data[47:32], remaining qw = (len+7)>>3 (17-bit arithmetic, no overflow), next slot = committed_cons+1.
REQ-024 PARSE, len==0 or qw > 2**BW-2: committed_cons <= committed_cons+1, bad_hdrs saturating +1, go to IDLE.
REQ-025 PARSE otherwise: go to REQ with burst_sop set.
REQ-026 REQ: burst_req high, burst_qw = min(remaining, MAX_BURST), burst_eop = (remaining <= MAX_BURST); all burst_* outputs SHALL hold stable until accepted.
REQ-027 On accept: next slot += burst_qw, remaining -= burst_qw, burst_sop cleared; go to REQ if remaining > 0, else go to WAIT_DONE.
REQ-028 WAIT_DONE: on burst_done go to COMMIT; burst_done in any other state SHALL be ignored.
REQ-029 COMMIT: committed_cons <= next slot (header + 1 + total qw), fwd_pkts +1 (wrapping), go to IDLE; no other cycle updates committed_cons except REQ-024.
REQ-030 committed_cons SHALL never pass committed_prod; a burst SHALL never be issued for an uncommitted packet.
REQ-031 Bursts crossing the ibuf wrap point SHALL be issued unsplit; burst_addr wraps naturally and the DMA engine handles wrap.
REQ-032 Deasserting hst_rdy SHALL NOT abort an in-flight packet; the state machine returns to WAIT_HOST only from IDLE.

Reset
REQ-033 On rst: state INIT, committed_cons 0, rd_addr 0, burst_req 0, burst_addr 0, burst_qw 0, burst_len 0, burst_sop 0, burst_eop 0, fwd_pkts 0, bad_hdrs 0, synchroniser flops 0.
REQ-034 Reset mid-packet SHALL drop the packet without commit; the producer side is reset together with this block.

Structure
REQ-035 A shared package SHALL hold the header bit-field constants (LEN_HI=47, LEN_LO=32) and FSM state encodings, common with the frame writer.
REQ-036 No sub-module; the hst_rdy synchroniser is inline.

Verification
REQ-037 Single 60-byte packet at slot 0 (prod=9) -> one burst addr=1 qw=8 sop=eop=1 len=60; after done, cons=9, fwd_pkts=1.
REQ-038 1514-byte packet, MAX_BURST=16 -> 12 bursts (11x16, 1x14), sop only on first, eop only on last, cons advances by 191 only after done.
REQ-039 Header len=0 at slot 5 -> no burst, cons=6, bad_hdrs=1.
REQ-040 Packet header at slot 1020, len=64, BW=10 -> burst_addr=1021, qw=8, cons=1029 (bit BW set), no stall at wrap.
REQ-041 burst_ack held low 20 cycles -> burst_* stable throughout; reset asserted in WAIT_DONE -> all outputs at reset values next cycle, cons=0.
